// File: rtl/probe_display_scan.sv
// rtl/probe_display_scan.sv - probe word capture and multiplexed hex seven-segment scanner
module probe_display_scan #(
    parameter int DATA_W   = 16,
    parameter int NUM_SRC  = 4,
    parameter int SEL_W    = 5,
    parameter int SCAN_DIV = 50000,
    parameter int BLANK_LZ = 0
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [NUM_SRC*DATA_W-1:0] probe_bus,
    input  logic [SEL_W-1:0]          select,
    input  logic                      freeze,
    output logic [DATA_W-1:0]         hold_word,
    output logic                      sel_err,
    output logic [DATA_W/4-1:0]       an,
    output logic [6:0]                seg,
    output logic                      frame_done
);
    localparam int NUM_DIGITS = DATA_W / 4;
    localparam int DIG_W      = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DIV_W      = $clog2(SCAN_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NUM_DIGITS - 1);

    logic [DATA_W-1:0] selWord;
    logic              selValid;
    logic [DIV_W-1:0]  divCnt;
    logic [DIG_W-1:0]  dig;
    logic              tick;
    logic [3:0]        curNibble;
    logic              curBlank;

    // Hex nibble to active-low {g,f,e,d,c,b,a} pattern
    function automatic logic [6:0] hexToSeg(input logic [3:0] nib);
        case (nib)
            4'h0:    return 7'h40;
            4'h1:    return 7'h79;
            4'h2:    return 7'h24;
            4'h3:    return 7'h30;
            4'h4:    return 7'h19;
            4'h5:    return 7'h12;
            4'h6:    return 7'h02;
            4'h7:    return 7'h78;
            4'h8:    return 7'h00;
            4'h9:    return 7'h10;
            4'hA:    return 7'h08;
            4'hB:    return 7'h03;
            4'hC:    return 7'h46;
            4'hD:    return 7'h21;
            4'hE:    return 7'h06;
            default: return 7'h0E;
        endcase
    endfunction

    // Word mux; loop compare keeps an out-of-range select from indexing past the bus
    always_comb begin
        selWord  = '0;
        selValid = 32'(select) < 32'(NUM_SRC);
        for (int k = 0; k < NUM_SRC; k++) begin
            if (32'(select) == 32'(k)) begin
                selWord = probe_bus[k*DATA_W +: DATA_W];
            end
        end
    end

    // Snapshot the selected word unless frozen; invalid select shows zero and flags it
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hold_word <= '0;
            sel_err   <= 1'b0;
        end else if (!freeze) begin
            hold_word <= selValid ? selWord : '0;
            sel_err   <= !selValid;
        end
    end

    // Prescaler: one tick per SCAN_DIV cycles, on the last count
    assign tick = (divCnt == DIV_LAST);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            divCnt <= '0;
        end else begin
            divCnt <= tick ? '0 : divCnt + 1'b1;
        end
    end

    // Current digit nibble and leading-zero blank decision (digit 0 never blanks)
    always_comb begin
        curNibble = 4'h0;
        curBlank  = 1'b0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            if (dig == DIG_W'(d)) begin
                curNibble = hold_word[d*4 +: 4];
                curBlank  = (BLANK_LZ != 0) && (d > 0) && ((hold_word >> (4 * d)) == '0);
            end
        end
    end

    // Digit scanner: drive the current digit on each tick and advance
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            dig        <= '0;
            an         <= '1;
            seg        <= 7'h7F;
            frame_done <= 1'b0;
        end else if (tick) begin
            an         <= ~(NUM_DIGITS'(1) << dig);
            seg        <= curBlank ? 7'h7F : hexToSeg(curNibble);
            dig        <= (dig == DIG_LAST) ? '0 : dig + 1'b1;
            frame_done <= (dig == DIG_LAST);
        end else begin
            frame_done <= 1'b0;
        end
    end
endmodule

// File: tb/tb_probe_display_scan.sv
// tb/tb_probe_display_scan.sv - scoreboard bench for probe_display_scan
`timescale 1ns/1ps
module tb_probe_display_scan;
    localparam int DATA_W     = 16;
    localparam int NUM_SRC    = 4;
    localparam int SEL_W      = 5;
    localparam int SCAN_DIV   = 4;
    localparam int NUM_DIGITS = 4;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic [6:0] segB;
        logic       fd;
    } scanExp_t;

    logic                      clock;
    logic                      reset;
    logic [NUM_SRC*DATA_W-1:0] probeBus;
    logic [SEL_W-1:0]          select;
    logic                      freeze;
    logic [DATA_W-1:0]         holdA, holdB;
    logic                      errA, errB;
    logic [3:0]                anA, anB;
    logic [6:0]                segA, segB;
    logic                      fdA, fdB;

    int nCompared   = 0;
    int nMismatched = 0;

    scanExp_t   expQ[$];
    int         mDiv, mDig;
    logic [15:0] mHold;
    logic       mErr;
    logic [3:0] mAn;
    logic [6:0] mSeg, mSegB;
    bit         inReset;

    logic [6:0] segTab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    probe_display_scan #(.DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W),
                         .SCAN_DIV(SCAN_DIV), .BLANK_LZ(0)) dutA (
        .clock(clock), .reset(reset), .probe_bus(probeBus), .select(select), .freeze(freeze),
        .hold_word(holdA), .sel_err(errA), .an(anA), .seg(segA), .frame_done(fdA));

    probe_display_scan #(.DATA_W(DATA_W), .NUM_SRC(NUM_SRC), .SEL_W(SEL_W),
                         .SCAN_DIV(SCAN_DIV), .BLANK_LZ(1)) dutB (
        .clock(clock), .reset(reset), .probe_bus(probeBus), .select(select), .freeze(freeze),
        .hold_word(holdB), .sel_err(errB), .an(anB), .seg(segB), .frame_done(fdB));

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCompared++;
        if (got !== exp) begin
            nMismatched++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Index of the most significant non-zero nibble, 0 for an all-zero word
    function automatic int topNibble(input logic [15:0] w);
        int top = 0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (w[i*4 +: 4] != 4'h0) top = i;
        end
        return top;
    endfunction

    task automatic setWord(input int k, input logic [15:0] w);
        probeBus[k*16 +: 16] = w;
    endtask

    task automatic assertReset();
        reset = 1'b0;
        #1;
        mDiv = 0; mDig = 0; mHold = '0; mErr = 1'b0;
        mAn = 4'hF; mSeg = 7'h7F; mSegB = 7'h7F;
        inReset = 1'b1;
        expQ.delete();
        checkVal("rst_hold", 32'(holdA), 32'h0);
        checkVal("rst_err", 32'(errA), 32'h0);
        checkVal("rst_an", 32'(anA), 32'hF);
        checkVal("rst_seg", 32'(segA), 32'h7F);
        checkVal("rst_fd", 32'(fdA), 32'h0);
    endtask

    task automatic releaseReset();
        reset = 1'b1;
        inReset = 1'b0;
    endtask

    // Predict the coming edge, let it happen, then compare every output
    task automatic cycle();
        scanExp_t   e;
        bit         tickNow;
        logic [3:0] nib;
        logic       fdExp;
        tickNow = !inReset && (mDiv == SCAN_DIV - 1);
        if (tickNow) begin
            nib    = 4'((mHold >> (4 * mDig)) & 16'hF);
            e.an   = ~(4'b0001 << mDig);
            e.seg  = segTab[nib];
            e.segB = (mDig > topNibble(mHold)) ? 7'h7F : segTab[nib];
            e.fd   = (mDig == NUM_DIGITS - 1);
            expQ.push_back(e);
        end
        @(posedge clock);
        #1;
        fdExp = 1'b0;
        if (!inReset) begin
            mDiv = (mDiv == SCAN_DIV - 1) ? 0 : mDiv + 1;
            if (!freeze) begin
                mErr  = int'(select) >= NUM_SRC;
                mHold = mErr ? 16'h0 : probeBus[int'(select)*16 +: 16];
            end
            if (tickNow && expQ.size() > 0) begin
                e     = expQ.pop_front();
                mAn   = e.an;
                mSeg  = e.seg;
                mSegB = e.segB;
                fdExp = e.fd;
                mDig  = (mDig + 1) % NUM_DIGITS;
            end
        end
        checkVal("hold", 32'(holdA), 32'(mHold));
        checkVal("sel_err", 32'(errA), 32'(mErr));
        checkVal("an", 32'(anA), 32'(mAn));
        checkVal("seg", 32'(segA), 32'(mSeg));
        checkVal("frame_done", 32'(fdA), 32'(fdExp));
        checkVal("blank_hold", 32'(holdB), 32'(mHold));
        checkVal("blank_sel_err", 32'(errB), 32'(mErr));
        checkVal("blank_an", 32'(anB), 32'(mAn));
        checkVal("blank_seg", 32'(segB), 32'(mSegB));
        checkVal("blank_frame_done", 32'(fdB), 32'(fdExp));
    endtask

    task automatic runCycles(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        reset    = 1'b1;
        probeBus = '0;
        select   = '0;
        freeze   = 1'b0;
        inReset  = 1'b0;
        setWord(0, 16'h1234);
        setWord(1, 16'h5A0F);
        setWord(2, 16'h0000);
        setWord(3, 16'h0F00);
        #2;
        assertReset();
        runCycles(2);
        releaseReset();

        // First scan after reset release
        runCycles(3);
        checkVal("edge3_an", 32'(anA), 32'hF);
        checkVal("edge3_seg", 32'(segA), 32'h7F);
        cycle();
        checkVal("edge4_an", 32'(anA), 32'hE);
        checkVal("edge4_seg", 32'(segA), 32'h19);
        runCycles(4);
        checkVal("edge8_an", 32'(anA), 32'hD);
        checkVal("edge8_seg", 32'(segA), 32'h30);
        runCycles(8);
        checkVal("edge16_an", 32'(anA), 32'h7);
        checkVal("edge16_seg", 32'(segA), 32'h79);
        checkVal("edge16_fd", 32'(fdA), 32'h1);
        cycle();
        checkVal("edge17_fd", 32'(fdA), 32'h0);
        runCycles(15);

        // Select switch
        setWord(2, 16'hABCD);
        select = 5'd2;
        cycle();
        checkVal("sel2_hold", 32'(holdA), 32'hABCD);
        runCycles(32);

        // Out-of-range select
        select = 5'd7;
        cycle();
        checkVal("oor_err", 32'(errA), 32'h1);
        checkVal("oor_hold", 32'(holdA), 32'h0);
        runCycles(32);
        select = 5'd1;
        cycle();
        checkVal("sel1_err", 32'(errA), 32'h0);
        checkVal("sel1_hold", 32'(holdA), 32'h5A0F);
        runCycles(16);

        // Freeze wins over a simultaneous probe change
        select = 5'd0;
        setWord(0, 16'h00F0);
        runCycles(2);
        freeze = 1'b1;
        setWord(0, 16'hFFFF);
        select = 5'd3;
        runCycles(48);
        checkVal("frozen_hold", 32'(holdA), 32'h00F0);
        select = 5'd0;
        freeze = 1'b0;
        runCycles(32);
        checkVal("thawed_hold", 32'(holdA), 32'hFFFF);

        // Leading-zero blanking
        setWord(0, 16'h0050);
        runCycles(32);
        setWord(0, 16'h0000);
        runCycles(32);
        setWord(0, 16'h1004);
        runCycles(32);

        // Reset mid-frame while digit 2 is lit
        setWord(0, 16'h1234);
        for (int i = 0; i < 40 && mAn != 4'hB; i++) cycle();
        checkVal("reach_dig2_an", 32'(anA), 32'hB);
        assertReset();
        runCycles(2);
        releaseReset();
        runCycles(3);
        checkVal("rerun_edge3_an", 32'(anA), 32'hF);
        cycle();
        checkVal("rerun_edge4_an", 32'(anA), 32'hE);
        checkVal("rerun_edge4_seg", 32'(segA), 32'h19);
        runCycles(32);

        checkVal("queue_empty", 32'(expQ.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end
endmodule
